frame_tx_sequencer: RTL and testbench



---
 rtl/frame_tx_pkg.sv | 33 +++
 rtl/baud_tick_gen.sv | 30 +++
 rtl/frame_tx_sequencer.sv | 127 ++++++++++++
 tb/tb_frame_tx_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_tx_pkg.sv
// Shared types and frame layout for the serial frame transmitter.
// Frame vectors are indexed in transmission order: bit 0 leaves the line first.
package frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int FRAME_LEN  = 17;
  localparam int PARITY_POS = 10;

  // Both constants are written first-transmitted bit on the left.
  localparam logic [4:0] HEADER  = 5'b11110;
  localparam logic [5:0] TRAILER = 6'b101111;

  function automatic logic even_parity(input logic [4:0] data);
    return ^data;
  endfunction

  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [4:0] data,
                                                       input logic       parity);
    logic [FRAME_LEN-1:0] f;
    f = '0;
    for (int i = 0; i < 5; i++) f[i] = HEADER[4-i];
    for (int i = 0; i < 5; i++) f[5+i] = data[i];
    f[PARITY_POS] = parity;
    for (int i = 0; i < 6; i++) f[11+i] = TRAILER[5-i];
    return f;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: pulses bit_tick_o on the last cycle of every CLKS_PER_BIT-cycle period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_tick_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q;

  // Cycle counter within the current bit period, restarted by every frame load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clear_i) begin
      cnt_q <= 8'd0;
    end else if (enable_i) begin
      if (cnt_q == LAST_CNT) cnt_q <= 8'd0;
      else                   cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bit_tick_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/frame_tx_sequencer.sv
// Frame transmitter: handshake-loaded 17-bit frame shifted out LSB-of-vector first, then an idle gap.
// Define FRAME_TX_PARITY_EN to send even payload parity in the P slot (otherwise P is 0).
module frame_tx_sequencer
  import frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       tx_active,
  output logic       frame_done
);

  localparam logic [4:0] BIT_LAST = 5'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

  state_e               state_q;
  logic [FRAME_LEN-2:0] shreg_q;
  logic [4:0]           bit_cnt_q;
  logic [3:0]           gap_cnt_q;
  logic                 tx_out_q, data_ready_q, tx_active_q, frame_done_q;

  logic                 load_s, bit_tick_s, parity_s;
  logic [FRAME_LEN-1:0] frame_d;

`ifdef FRAME_TX_PARITY_EN
  assign parity_s = even_parity(data_in);
`else
  assign parity_s = 1'b0;
`endif

  assign frame_d = build_frame(data_in, parity_s);
  assign load_s  = (state_q == IDLE) && data_valid;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (load_s),
    .enable_i  (state_q != IDLE),
    .bit_tick_o(bit_tick_s)
  );

  // Sequencer: the first frame bit goes straight to tx_out_q, the rest wait in shreg_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= 5'd0;
      gap_cnt_q    <= 4'd0;
      tx_out_q     <= 1'b1;
      data_ready_q <= 1'b1;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_s) begin
            state_q      <= SHIFT;
            shreg_q      <= frame_d[FRAME_LEN-1:1];
            tx_out_q     <= frame_d[0];
            bit_cnt_q    <= 5'd0;
            data_ready_q <= 1'b0;
            tx_active_q  <= 1'b1;
          end else begin
            tx_out_q     <= 1'b1;
            data_ready_q <= 1'b1;
            tx_active_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_tick_s) begin
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= 5'd0;
              tx_out_q  <= 1'b1;
              if (GAP_BITS > 0) begin
                state_q   <= GAP;
                gap_cnt_q <= 4'd0;
              end else begin
                state_q      <= IDLE;
                data_ready_q <= 1'b1;
                tx_active_q  <= 1'b0;
                frame_done_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              tx_out_q  <= shreg_q[0];
              shreg_q   <= {1'b0, shreg_q[FRAME_LEN-2:1]};
            end
          end
        end
        GAP: begin
          if (bit_tick_s) begin
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_q    <= 4'd0;
              state_q      <= IDLE;
              data_ready_q <= 1'b1;
              tx_active_q  <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          tx_out_q     <= 1'b1;
          data_ready_q <= 1'b1;
          tx_active_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = data_ready_q;
  assign tx_out     = tx_out_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Scoreboard bench: three sequencer instances with different rate/gap settings share clock and reset.
module tb_frame_tx_sequencer;

  localparam int C0 = 1, G0 = 2;
  localparam int C1 = 4, G1 = 0;
  localparam int C2 = 1, G2 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] din0, din1, din2;
  logic [2:0] dv;
  wire  [2:0] tx, rdy, act, dn;
  logic [1:0] sel;
  wire  [3:0] obs = {tx[sel], rdy[sel], act[sel], dn[sel]};

  logic [3:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_tx_sequencer #(.CLKS_PER_BIT(C0), .GAP_BITS(G0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din0), .data_valid(dv[0]),
    .data_ready(rdy[0]), .tx_out(tx[0]), .tx_active(act[0]), .frame_done(dn[0]));
  frame_tx_sequencer #(.CLKS_PER_BIT(C1), .GAP_BITS(G1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din1), .data_valid(dv[1]),
    .data_ready(rdy[1]), .tx_out(tx[1]), .tx_active(act[1]), .frame_done(dn[1]));
  frame_tx_sequencer #(.CLKS_PER_BIT(C2), .GAP_BITS(G2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(din2), .data_valid(dv[2]),
    .data_ready(rdy[2]), .tx_out(tx[2]), .tx_active(act[2]), .frame_done(dn[2]));

  // Reference frame, index 0 transmitted first: 1,1,1,1,0,d0..d4,P,1,0,1,1,1,1
  function automatic logic [16:0] exp_frame(input logic [4:0] d);
    logic p;
`ifdef FRAME_TX_PARITY_EN
    p = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[4];
`else
    p = 1'b0;
`endif
    return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, p,
            d[4], d[3], d[2], d[1], d[0], 1'b0, 4'b1111};
  endfunction

  // Expected per-cycle {tx, ready, active, done} from handshake+1 to the frame_done cycle.
  task automatic push_frame(input logic [4:0] d, input int c, input int g);
    logic [16:0] f;
    f = exp_frame(d);
    for (int i = 0; i < 17; i++)
      for (int j = 0; j < c; j++) sb_q.push_back({f[i], 1'b0, 1'b1, 1'b0});
    for (int j = 0; j < g * c; j++) sb_q.push_back(4'b1010);
    sb_q.push_back(4'b1101);
  endtask

  task automatic handshake(input int s, input logic [4:0] d, input int c, input int g);
    @(negedge clk);
    case (s)
      0: din0 = d;
      1: din1 = d;
      default: din2 = d;
    endcase
    dv[s] = 1'b1;
    push_frame(d, c, g);
    @(negedge clk);
    dv[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dv = 3'b000; din0 = 5'd0; din1 = 5'd0; din2 = 5'd0; sel = 2'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #0;
      checks++;
      if (obs !== 4'b1100) begin
        errors++;
        $display("FAIL reset_value dut%0d got %b expected 1100", s, obs);
      end
    end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        sel = 2'(s);
        #0;
        checks++;
        if (obs !== 4'b1100) begin
          errors++;
          $display("FAIL idle dut%0d cycle %0d got %b expected 1100", s, cyc, obs);
        end
      end
    end
  endtask

  task automatic test_frame_c1_g2(input logic [4:0] d);
    int n;
    logic [3:0] e;
    sel = 2'd0;
    handshake(0, d, C0, G0);
    n = 1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL frame_c1_g2 d=%b cycle k+%0d got %b expected %b", d, n, obs, e);
      end
      n++;
      if (sb_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_slow_no_gap(input logic [4:0] d);
    int n;
    logic [3:0] e;
    sel = 2'd1;
    handshake(1, d, C1, G1);
    n = 1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL slow_no_gap d=%b cycle k+%0d got %b expected %b", d, n, obs, e);
      end
      n++;
      if (sb_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pay[3];
    int fidx, n;
    logic [3:0] e;
    pay[0] = 5'b10110; pay[1] = 5'b01001; pay[2] = 5'b11100;
    sel = 2'd2;
    @(negedge clk);
    din2 = pay[0];
    dv[2] = 1'b1;
    push_frame(pay[0], C2, G2);
    @(negedge clk);
    fidx = 0;
    n = 1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back frame %0d cycle %0d got %b expected %b", fidx, n, obs, e);
      end
      n++;
      if (e[0]) begin
        if (fidx < 2) begin
          fidx++;
          din2 = pay[fidx];
          push_frame(pay[fidx], C2, G2);
        end else begin
          dv[2] = 1'b0;
        end
      end
      if (sb_q.size() > 0) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL back_to_back_idle got %b expected 1100", obs);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [3:0] e;
    sel = 2'd0;
    handshake(0, 5'b11011, C0, G0);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pre_reset cycle k+%0d got %b expected %b", i + 1, obs, e);
      end
      if (i < 7) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL async_reset got %b expected 1100", obs);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    handshake(0, 5'b01001, C0, G0);
    n = 1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fresh_frame cycle k+%0d got %b expected %b", n, obs, e);
      end
      n++;
      if (sb_q.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_frame_c1_g2(5'b10110);
    test_frame_c1_g2(5'b00011);
    test_slow_no_gap(5'b11111);
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
